// File: rtl/imem_loader_pkg.sv
// Shared types and field widths for the instruction-memory program loader.
package imem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    // master: host/debug side feeding bytes and observing memory writes
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // slave: the loader itself
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Packs payload bytes MSB-first into 32-bit words and keeps the running XOR checksum.
// Latency: word_rdy/word_dat are combinational with the 4th byte; checksum updates on the clock edge.
// Backpressure: none; consumes every byte_vld it is given.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [BYTE_W-1:0] byte_dat,
    output logic              word_rdy,
    output logic [WORD_W-1:0] word_dat,
    output logic [BYTE_W-1:0] csum
);

    localparam int BUF_W = WORD_W - BYTE_W;

    logic [BUF_W-1:0] buf_q;
    logic [1:0]       idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            buf_q <= '0;
            idx_q <= '0;
            csum  <= '0;
        end else if (byte_vld) begin
            buf_q <= {buf_q[BUF_W-BYTE_W-1:0], byte_dat};
            idx_q <= idx_q + 2'd1;
            csum  <= csum ^ byte_dat;
        end
    end

    // The completed word includes the byte arriving this cycle.
    assign word_rdy = byte_vld && (idx_q == 2'd3);
    assign word_dat = {buf_q, byte_dat};

endmodule

// File: rtl/imem_loader.sv
// Loads a framed, checksummed program into instruction memory and holds the core until it succeeds.
// Latency: mem_we is registered, one cycle after the last byte of each word.
// Backpressure: in_ready only in LEN_HI/LEN_LO/DATA/CHECK; memory side never stalls.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'd0,
    parameter int                MAX_WORDS = 18,
    parameter int                CNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    imem_loader_if.slave   bus,
    output logic           cpu_hold,
    output logic           done,
    output logic           error
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

    state_t            state;
    logic [BYTE_W-1:0] len_hi;
    logic [CNT_W-1:0]  n_words;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  len_now;
    logic              accept;
    logic              arm;
    logic              word_rdy;
    logic [WORD_W-1:0] word_dat;
    logic [BYTE_W-1:0] csum;

    assign accept  = bus.in_valid && bus.in_ready;
    assign arm     = start && (state == IDLE || state == DONE || state == ERR);
    assign len_now = CNT_W'({len_hi, bus.in_data});

    byte_word_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (arm),
        .byte_vld (accept && (state == DATA)),
        .byte_dat (bus.in_data),
        .word_rdy (word_rdy),
        .word_dat (word_dat),
        .csum     (csum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            len_hi        <= '0;
            n_words       <= '0;
            word_cnt      <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN_HI;
                        bus.in_ready <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        n_words      <= '0;
                        word_cnt     <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_hi <= bus.in_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        n_words <= len_now;
                        if (len_now > MAX_N) begin
                            state        <= ERR;
                            bus.in_ready <= 1'b0;
                            error        <= 1'b1;
                        end else if (len_now == '0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_rdy) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= BASE_ADDR + (ADDR_W'(word_cnt) << 2);
                        bus.mem_wdata <= word_dat;
                        word_cnt      <= word_cnt + CNT_W'(1);
                        if (word_cnt + CNT_W'(1) == n_words) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        bus.in_ready <= 1'b0;
                        if (bus.in_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus hand-written corner sequences.
module tb_imem_loader;

    typedef struct {
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  cs;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    logic start;
    logic cpu_hold;
    logic done;
    logic error;

    int  errors = 0;
    int  checks = 0;
    bit  gaps   = 0;
    wr_t exp_q[$];
    vec_t vt[8];

    imem_loader_if bus ();

    imem_loader #(
        .BASE_ADDR (32'd0),
        .MAX_WORDS (18),
        .CNT_W     (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write: got addr %h data %h expected addr %h data %h",
                                 bus.mem_addr, bus.mem_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return {b, b, ~b, ~b};
    endfunction

    // Tasks start and end at a negedge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 100 cycles expected 1");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        wr_t e;
        logic [31:0] w;
        pulse_start();
        chk({tag, "_armed_done"}, 32'(done), 32'd0);
        chk({tag, "_armed_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_armed_ready"}, 32'(bus.in_ready), 32'd1);
        send_byte(v.len[15:8]);
        send_byte(v.len[7:0]);
        if (v.len <= 16'd18) begin
            for (int i = 0; i < int'(v.len); i++) begin
                w = word_of(v, i);
                e.addr = 32'(i) * 4;
                e.data = w;
                exp_q.push_back(e);
                send_word(w);
            end
            send_byte(v.cs);
        end
        repeat (2) @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'(v.exp_done));
        chk({tag, "_error"}, 32'(error), 32'(v.exp_err));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!v.exp_done));
        chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        wr_t e;
        vt[0] = '{16'd1,  32'h2001000A, 32'h00000000, 8'h2B, 1'b1, 1'b0};
        vt[1] = '{16'd2,  32'h8C010001, 32'hAC020002, 8'h20, 1'b1, 1'b0};
        vt[2] = '{16'd2,  32'h8C010001, 32'hAC020002, 8'h05, 1'b0, 1'b1};
        vt[3] = '{16'd1,  32'h2001000A, 32'h00000000, 8'h00, 1'b0, 1'b1};
        vt[4] = '{16'd19, 32'h00000000, 32'h00000000, 8'h00, 1'b0, 1'b1};
        vt[5] = '{16'd0,  32'h00000000, 32'h00000000, 8'h00, 1'b1, 1'b0};
        vt[6] = '{16'd0,  32'h00000000, 32'h00000000, 8'h01, 1'b0, 1'b1};
        vt[7] = '{16'd18, 32'h01020304, 32'h00000000, 8'h04, 1'b1, 1'b0};

        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) run_frame(vt[k], $sformatf("vec%0d", k));

        // Random valid gaps must give the same result; then in_valid while not ready is ignored.
        gaps = 1;
        run_frame(vt[1], "gap_n2");
        run_frame(vt[5], "gap_n0");
        gaps = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("idle_valid_done", 32'(done), 32'd1);
        chk("idle_valid_ready", 32'(bus.in_ready), 32'd0);

        // start mid-frame is ignored.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h01);
        pulse_start();
        e.addr = 32'h0;
        e.data = 32'h2001000A;
        exp_q.push_back(e);
        send_byte(8'h00);
        send_byte(8'h0A);
        send_byte(8'h2B);
        repeat (2) @(negedge clk);
        chk("midstart_done", 32'(done), 32'd1);
        chk("midstart_writes", 32'(exp_q.size()), 32'd0);

        // Reset after 6 payload bytes aborts the frame.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        e.addr = 32'h0;
        e.data = 32'h8C010001;
        exp_q.push_back(e);
        send_word(32'h8C010001);
        send_byte(8'hAC);
        send_byte(8'h02);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        chk("midrst_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_frame(vt[1], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
